bsf_32: RTL and testbench

BSF_32 -- requirements
Module: bsf_32

---
 rtl/bsf_32.sv | 67 ++++++
 tb/tb_bsf_32.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bsf_32.sv
// Registered 32-bit bit-scan-forward: index of the lowest set bit, plus a nonzero flag.
// Four 8-bit group scans run in parallel; the lowest nonzero group selects the final index.

module bsf_32_grp (
  input  logic [7:0] d_i,
  output logic       nz_o,
  output logic [2:0] idx_o
);
  // Scan from the top down so that the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = 7; i >= 0; i--)
      if (d_i[i]) idx_o = 3'(i);
  end

  assign nz_o = |d_i;
endmodule

module bsf_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in,
  output logic [4:0]  out,
  output logic        v
);
  localparam int NUM_GRP = 4;
  localparam int GRP_W   = 8;

  logic [NUM_GRP-1:0]      grp_nz;
  logic [NUM_GRP-1:0][2:0] grp_idx;
  logic [1:0]              gsel;
  logic [4:0]              out_d, out_q;
  logic                    v_d, v_q;

  genvar g;
  generate
    for (g = 0; g < NUM_GRP; g++) begin : g_grp
      bsf_32_grp u_grp (
        .d_i   (in[g*GRP_W +: GRP_W]),
        .nz_o  (grp_nz[g]),
        .idx_o (grp_idx[g])
      );
    end
  endgenerate

  // With no set bit, gsel stays 0 and group 0 reports index 0, so out_d is 0.
  always_comb begin
    gsel = '0;
    for (int i = NUM_GRP - 1; i >= 0; i--)
      if (grp_nz[i]) gsel = 2'(i);
    out_d = {gsel, grp_idx[gsel]};
    v_d   = |grp_nz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      v_q   <= 1'b0;
    end else begin
      out_q <= out_d;
      v_q   <= v_d;
    end
  end

  assign out = out_q;
  assign v   = v_q;
endmodule

// File: tb/tb_bsf_32.sv
// Self-checking bench for bsf_32: vector table, walking ones, random stream, and reset corners.

module tb_bsf_32;
  logic        clk;
  logic        rst_n;
  logic [31:0] in;
  logic [4:0]  out;
  logic        v;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] din;
    logic [4:0]  exp_out;
    logic        exp_v;
  } vec_t;

  typedef struct {
    logic [4:0] exp_out;
    logic       exp_v;
    string      name;
  } exp_t;

  exp_t sb[$];

  bsf_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out),
    .v     (v)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] ref_bsf(input logic [31:0] x);
    logic found;
    logic [4:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 32; i++)
      if (x[i] && !found) begin
        idx   = 5'(i);
        found = 1'b1;
      end
    return {found, idx};
  endfunction

  task automatic chk(input string name, input logic [4:0] eo, input logic ev);
    checks++;
    if (out !== eo || v !== ev) begin
      failures++;
      $display("FAIL %s: got out=%0d v=%b, expected out=%0d v=%b", name, out, v, eo, ev);
    end
  endtask

  // Drive one operand (away from the edge), record the expectation, compare after the next edge.
  task automatic drive(input logic [31:0] val, input logic [4:0] eo, input logic ev, input string name);
    exp_t e;
    in = val;
    e.exp_out = eo;
    e.exp_v   = ev;
    e.name    = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, expected one entry", name);
    end else begin
      e = sb.pop_front();
      chk(e.name, e.exp_out, e.exp_v);
    end
  endtask

  task automatic drive_ref(input logic [31:0] val, input string name);
    logic [5:0] r;
    r = ref_bsf(val);
    drive(val, r[4:0], r[5], name);
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] val;

    vecs[0] = '{32'h1000_0000, 5'd28, 1'b1};
    vecs[1] = '{32'h2000_0000, 5'd29, 1'b1};
    vecs[2] = '{32'h0000_FFFF, 5'd0,  1'b1};
    vecs[3] = '{32'h00FF_FF00, 5'd8,  1'b1};
    vecs[4] = '{32'h0000_00FF, 5'd0,  1'b1};
    vecs[5] = '{32'h0000_0000, 5'd0,  1'b0};
    vecs[6] = '{32'h8000_0000, 5'd31, 1'b1};
    vecs[7] = '{32'h0000_0001, 5'd0,  1'b1};
    vecs[8] = '{32'hFFFF_FFFF, 5'd0,  1'b1};

    // Reset state, with clock edges and a nonzero operand present during reset.
    rst_n = 1'b0;
    in    = 32'h0000_0100;
    #2;
    chk("reset_async", 5'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", 5'd0, 1'b0);

    // First result after release belongs to the operand present at the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0000_0040, 5'd6, 1'b1, "first_after_reset");

    for (int i = 0; i < 9; i++)
      drive(vecs[i].din, vecs[i].exp_out, vecs[i].exp_v, $sformatf("vec%0d", i));

    for (int i = 0; i < 32; i++) begin
      val = 32'h1 << i;
      drive(val, 5'(i), 1'b1, $sformatf("walk1_%0d", i));
    end
    for (int i = 0; i < 32; i++) begin
      val = 32'hFFFF_FFFF << i;
      drive(val, 5'(i), 1'b1, $sformatf("walkhi_%0d", i));
    end

    for (int i = 0; i < 100; i++) begin
      case ($urandom_range(0, 3))
        0:       val = $urandom;
        1:       val = $urandom << $urandom_range(0, 31);
        2:       val = 32'h1 << $urandom_range(0, 31);
        default: val = (i % 10 == 0) ? 32'h0 : ($urandom & ($urandom << 16));
      endcase
      drive_ref(val, $sformatf("rand%0d", i));
    end

    // Mid-stream reset while v=1: outputs clear immediately, pending result is dropped.
    drive(32'h0000_2000, 5'd13, 1'b1, "pre_midreset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_immediate", 5'd0, 1'b0);
    sb.delete();
    in = 32'h0004_0000;
    @(posedge clk);
    #1;
    chk("midreset_ignored", 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0000_0400, 5'd10, 1'b1, "post_midreset");
    drive(32'h0000_0000, 5'd0, 1'b0, "post_midreset_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
